ts_tx_serializer: RTL and testbench

TS_TX_SERIALIZER -- requirements
Module: ts_tx_serializer

---
 rtl/ts_tx_serializer_pkg.sv | 29 ++
 rtl/ts_tx_serializer_if.sv | 25 ++
 rtl/ts_tx_serializer_fifo.sv | 61 ++++++
 rtl/ts_tx_serializer.sv | 160 ++++++++++++++++
 tb/tb_ts_tx_serializer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ts_tx_serializer_pkg.sv
// Shared TS transmit constants and symbol helpers.
// The TS generator imports the same package, so both sides agree on the K-code values.
package ts_tx_serializer_pkg;

  localparam int TS_W = 128;

  localparam logic [7:0] SYM_COM    = 8'hBC;
  localparam logic [7:0] SYM_PADG12 = 8'hF7;
  localparam logic [7:0] SYM_IDLE   = 8'h00;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_IDLE,
    ST_SEND
  } tx_state_t;

  // Symbol 0 sits in the top byte of the ordered set.
  function automatic logic [7:0] ts_symbol(input logic [TS_W-1:0] ts, input logic [3:0] idx);
    logic [TS_W-1:0] sh;
    sh = ts >> {4'd15 - idx, 3'b000};
    return sh[7:0];
  endfunction

  function automatic logic ts_is_k(input logic [3:0] idx, input logic [7:0] sym);
    return ((idx == 4'd0) && (sym == SYM_COM)) ||
           (((idx == 4'd1) || (idx == 4'd2)) && (sym == SYM_PADG12));
  endfunction

endpackage

// File: rtl/ts_tx_serializer_if.sv
// TS ingress and symbol egress bundle between the TS generator, the serializer and the PHY.
// The master modport is the generator/PHY side; the slave modport is the serializer.
interface ts_tx_serializer_if;
  import ts_tx_serializer_pkg::*;

  logic [TS_W-1:0] ts_in;
  logic            ts_in_valid;
  logic            ts_tx_fifo_full;
  logic [7:0]      tx_sym;
  logic            tx_k;
  logic            tx_sym_valid;
  logic            tx_sym_first;
  logic            tx_elec_idle;

  modport master (
    output ts_in, ts_in_valid,
    input  ts_tx_fifo_full, tx_sym, tx_k, tx_sym_valid, tx_sym_first, tx_elec_idle
  );

  modport slave (
    input  ts_in, ts_in_valid,
    output ts_tx_fifo_full, tx_sym, tx_k, tx_sym_valid, tx_sym_first, tx_elec_idle
  );

endinterface

// File: rtl/ts_tx_serializer_fifo.sv
// Occupancy-counted FIFO holding whole ordered sets between the generator and the serializer.
// almost_full is registered from the next occupancy so it tracks the count without lag.
module ts_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             almost_full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (wr_ok && !rd_ok)
      count_nxt = count + 1'b1;
    else if (rd_ok && !wr_ok)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      almost_full <= (count_nxt >= CW'(DEPTH - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ts_tx_serializer.sv
// Buffers 128-bit ordered sets and serializes them into symbols at 2.5 or 5 GT/s pacing.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  OFF     | electrical idle, no symbols, FIFO untouched
//  IDLE    | enabled; each strobe pops a TS or sends logical idle
//  SEND    | walking symbols of the current TS; idx==0 means next TS pending
module ts_tx_serializer
  import ts_tx_serializer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  ts_tx_serializer_if.slave   bus,
  input  logic                speed,
  input  logic                tx_enable,
  output logic                overflow_err,
  output logic [7:0]          underrun_cnt
);

  tx_state_t       state;
  logic [1:0]      div;
  logic            speed_l;
  logic [3:0]      idx;
  logic [TS_W-1:0] cur;
  logic [TS_W-1:0] head;
  logic            fifo_full;
  logic            fifo_afull;
  logic            fifo_empty;
  logic            strobe;
  logic            pop;
  logic [1:0]      reload;
  logic [7:0]      head_sym0;
  logic [7:0]      cur_sym;

  logic [7:0]      sym_q;
  logic            k_q;
  logic            valid_q;
  logic            first_q;
  logic            idle_q;

  ts_fifo #(
    .WIDTH (TS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (bus.ts_in_valid),
    .wr_data     (bus.ts_in),
    .rd_en       (pop),
    .rd_data     (head),
    .full        (fifo_full),
    .almost_full (fifo_afull),
    .empty       (fifo_empty)
  );

  assign strobe = (div == 2'd0);
  assign pop    = strobe && tx_enable && !fifo_empty &&
                  ((state == ST_IDLE) || ((state == ST_SEND) && (idx == 4'd0)));
  // A pop takes the live speed so the whole TS is paced by the rate it started at.
  assign reload    = (pop ? speed : speed_l) ? 2'd1 : 2'd3;
  assign head_sym0 = ts_symbol(head, 4'd0);
  assign cur_sym   = ts_symbol(cur, idx);

  assign bus.ts_tx_fifo_full = fifo_afull;
  assign bus.tx_sym          = sym_q;
  assign bus.tx_k            = k_q;
  assign bus.tx_sym_valid    = valid_q;
  assign bus.tx_sym_first    = first_q;
  assign bus.tx_elec_idle    = idle_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_OFF;
      div          <= 2'd0;
      speed_l      <= 1'b0;
      idx          <= 4'd0;
      cur          <= '0;
      sym_q        <= 8'd0;
      k_q          <= 1'b0;
      valid_q      <= 1'b0;
      first_q      <= 1'b0;
      idle_q       <= 1'b1;
      overflow_err <= 1'b0;
      underrun_cnt <= 8'd0;
    end else begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      div     <= strobe ? reload : div - 2'd1;
      if (bus.ts_in_valid && fifo_full) overflow_err <= 1'b1;
      if (pop) begin
        speed_l <= speed;
        cur     <= head;
      end

      case (state)
        ST_OFF: begin
          idle_q <= 1'b1;
          if (tx_enable) begin
            state  <= ST_IDLE;
            idle_q <= 1'b0;
          end
        end

        ST_IDLE: begin
          if (!tx_enable) begin
            state  <= ST_OFF;
            idle_q <= 1'b1;
          end else if (strobe) begin
            valid_q <= 1'b1;
            if (pop) begin
              sym_q   <= head_sym0;
              k_q     <= ts_is_k(4'd0, head_sym0);
              first_q <= 1'b1;
              idx     <= 4'd1;
              state   <= ST_SEND;
            end else begin
              sym_q <= SYM_IDLE;
              k_q   <= 1'b0;
            end
          end
        end

        ST_SEND: begin
          if (strobe) begin
            if (idx == 4'd0) begin
              if (pop) begin
                valid_q <= 1'b1;
                sym_q   <= head_sym0;
                k_q     <= ts_is_k(4'd0, head_sym0);
                first_q <= 1'b1;
                idx     <= 4'd1;
              end else begin
                state <= tx_enable ? ST_IDLE : ST_OFF;
              end
            end else begin
              valid_q <= 1'b1;
              sym_q   <= cur_sym;
              k_q     <= ts_is_k(idx, cur_sym);
              idx     <= idx + 4'd1;
              // Symbol 15: a waiting TS follows on the next strobe via idx wrapping to 0.
              if (idx == 4'd15) begin
                if (!tx_enable) begin
                  state <= ST_OFF;
                end else if (fifo_empty) begin
                  state <= ST_IDLE;
                  if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
                end
              end
            end
          end
        end

        default: state <= ST_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_ts_tx_serializer.sv
// Self-checking bench for ts_tx_serializer: random TS streams against a byte-queue reference model.
module tb_ts_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       speed = 1'b0;
  logic       tx_enable = 1'b0;
  logic       overflow_err;
  logic [7:0] underrun_cnt;

  ts_tx_serializer_if ifc ();

  ts_tx_serializer #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (ifc),
    .speed        (speed),
    .tx_enable    (tx_enable),
    .overflow_err (overflow_err),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] sym;
    logic       k;
    logic       first;
    logic [7:0] urun;
  } pulse_t;

  pulse_t     mon_q[$];
  logic [7:0] exp_q[$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (ifc.tx_sym_valid === 1'b1)
      mon_q.push_back('{cyc, ifc.tx_sym, ifc.tx_k, ifc.tx_sym_first, underrun_cnt});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at 2 ms, expected finish");
    $fatal(1, "watchdog");
  end

  // Reference K-code rule: COM at position 0, PAD at positions 1-2.
  function automatic logic exp_k(input int pos, input logic [7:0] s);
    return ((pos == 0) && (s == 8'hBC)) || (((pos == 1) || (pos == 2)) && (s == 8'hF7));
  endfunction

  task automatic add_ts(input bit poll, input bit keep, output logic [127:0] ts);
    logic [7:0] s;
    ts = '0;
    for (int i = 0; i < 16; i++) begin
      if (poll) begin
        s = (i == 0) ? 8'hBC : (i < 3) ? 8'hF7 : (i == 3) ? 8'hFF :
            (i == 4) ? 8'h10 : (i == 5) ? 8'h02 : 8'h4A;
      end else begin
        s = 8'($urandom);
        if (i == 0 && $urandom_range(0, 3) != 0) s = 8'hBC;
        if ((i == 1 || i == 2) && $urandom_range(0, 1) != 0) s = 8'hF7;
        if (i >= 3 && $urandom_range(0, 7) == 0) s = ($urandom_range(0, 1) != 0) ? 8'hBC : 8'hF7;
      end
      ts = {ts[119:0], s};
      if (keep) exp_q.push_back(s);
    end
  endtask

  task automatic write_ts(input logic [127:0] ts);
    ifc.ts_in       = ts;
    ifc.ts_in_valid = 1'b1;
    @(posedge clk); #1;
    ifc.ts_in_valid = 1'b0;
  endtask

  task automatic get_pulse(output pulse_t p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mon_q.size() > 0) begin
        p  = mon_q.pop_front();
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL pulse_timeout: got no tx_sym_valid in 200 cycles, expected a symbol");
  endtask

  task automatic find_first(output pulse_t p, output bit ok);
    for (int i = 0; i < 50; i++) begin
      get_pulse(p, ok);
      if (!ok) return;
      if (p.first === 1'b1) return;
    end
    ok = 1'b0;
    checks++; errors++;
    $display("FAIL first_timeout: got no tx_sym_first in 50 symbols, expected one");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_enable = 1'b0;
    speed = 1'b0;
    ifc.ts_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ifc.tx_sym !== 8'h00) begin errors++; $display("FAIL rst_sym: got %h want 00", ifc.tx_sym); end
    checks++; if (ifc.tx_k !== 1'b0) begin errors++; $display("FAIL rst_k: got %b want 0", ifc.tx_k); end
    checks++; if (ifc.tx_sym_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ifc.tx_sym_valid); end
    checks++; if (ifc.tx_sym_first !== 1'b0) begin errors++; $display("FAIL rst_first: got %b want 0", ifc.tx_sym_first); end
    checks++; if (ifc.tx_elec_idle !== 1'b1) begin errors++; $display("FAIL rst_elec_idle: got %b want 1", ifc.tx_elec_idle); end
    checks++; if (ifc.ts_tx_fifo_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", ifc.ts_tx_fifo_full); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow_err); end
    checks++; if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL rst_underrun: got %0d want 0", underrun_cnt); end
  endtask

  task automatic test_single_ts();
    pulse_t p; bit ok; logic [127:0] ts; logic [7:0] e; int prev;
    do_reset();
    tx_enable = 1'b1;
    repeat (3) @(posedge clk); #1;
    add_ts(1'b1, 1'b1, ts);
    write_ts(ts);
    find_first(p, ok);
    if (!ok) return;
    prev = p.cyc;
    for (int n = 0; n < 16; n++) begin
      if (n > 0) begin get_pulse(p, ok); if (!ok) return; end
      e = exp_q.pop_front();
      checks++; if (p.sym !== e) begin errors++; $display("FAIL single_sym[%0d]: got %h want %h", n, p.sym, e); end
      checks++; if (p.k !== exp_k(n, e)) begin errors++; $display("FAIL single_k[%0d]: got %b want %b", n, p.k, exp_k(n, e)); end
      checks++; if (p.first !== (n == 0)) begin errors++; $display("FAIL single_first[%0d]: got %b want %b", n, p.first, n == 0); end
      if (n > 0) begin
        checks++; if (p.cyc - prev != 4) begin errors++; $display("FAIL single_gap[%0d]: got %0d want 4", n, p.cyc - prev); end
      end
      prev = p.cyc;
    end
    get_pulse(p, ok);
    if (!ok) return;
    checks++; if (p.sym !== 8'h00 || p.k !== 1'b0 || p.first !== 1'b0) begin errors++; $display("FAIL single_idle: got sym=%h k=%b first=%b want 00/0/0", p.sym, p.k, p.first); end
    checks++; if (p.cyc - prev != 4) begin errors++; $display("FAIL single_idle_gap: got %0d want 4", p.cyc - prev); end
    checks++; if (p.urun !== 8'd1) begin errors++; $display("FAIL single_underrun: got %0d want 1", p.urun); end
  endtask

  task automatic test_back_to_back();
    pulse_t p; bit ok; logic [127:0] ts; logic [7:0] e; int prev; int pos;
    do_reset();
    speed = 1'b1;
    tx_enable = 1'b1;
    repeat (3) @(posedge clk); #1;
    for (int t = 0; t < 3; t++) begin add_ts(1'b0, 1'b1, ts); write_ts(ts); end
    find_first(p, ok);
    if (!ok) return;
    prev = p.cyc;
    for (int n = 0; n < 48; n++) begin
      if (n > 0) begin get_pulse(p, ok); if (!ok) return; end
      pos = n % 16;
      e = exp_q.pop_front();
      checks++; if (p.sym !== e) begin errors++; $display("FAIL b2b_sym[%0d]: got %h want %h", n, p.sym, e); end
      checks++; if (p.k !== exp_k(pos, e)) begin errors++; $display("FAIL b2b_k[%0d]: got %b want %b", n, p.k, exp_k(pos, e)); end
      checks++; if (p.first !== (pos == 0)) begin errors++; $display("FAIL b2b_first[%0d]: got %b want %b", n, p.first, pos == 0); end
      if (n > 0) begin
        checks++; if (p.cyc - prev != 2) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d want 2", n, p.cyc - prev); end
      end
      if (n == 46) begin
        checks++; if (p.urun !== 8'd0) begin errors++; $display("FAIL b2b_underrun: got %0d want 0", p.urun); end
      end
      prev = p.cyc;
    end
  endtask

  task automatic test_random_speed();
    pulse_t p; bit ok; logic [127:0] ts; logic [7:0] e; int prev; int pos; int gap; int nts;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      speed = 1'($urandom_range(0, 1));
      gap = speed ? 2 : 4;
      nts = $urandom_range(1, 3);
      tx_enable = 1'b1;
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #1;
      for (int t = 0; t < nts; t++) begin add_ts(1'b0, 1'b1, ts); write_ts(ts); end
      find_first(p, ok);
      if (!ok) return;
      prev = p.cyc;
      for (int n = 0; n < nts * 16; n++) begin
        if (n > 0) begin get_pulse(p, ok); if (!ok) return; end
        pos = n % 16;
        e = exp_q.pop_front();
        checks++; if (p.sym !== e || p.k !== exp_k(pos, e) || p.first !== (pos == 0)) begin
          errors++; $display("FAIL rnd_sym[%0d]: got %h/%b/%b want %h/%b/%b", n, p.sym, p.k, p.first, e, exp_k(pos, e), pos == 0);
        end
        if (n > 0) begin
          checks++; if (p.cyc - prev != gap) begin errors++; $display("FAIL rnd_gap[%0d]: got %0d want %0d", n, p.cyc - prev, gap); end
        end
        prev = p.cyc;
      end
      get_pulse(p, ok);
      if (!ok) return;
      checks++; if (p.sym !== 8'h00 || p.urun !== 8'd1) begin errors++; $display("FAIL rnd_tail: got sym=%h urun=%0d want 00/1", p.sym, p.urun); end
    end
  endtask

  task automatic test_overflow();
    pulse_t p; bit ok; logic [127:0] ts; logic [7:0] e;
    do_reset();
    speed = 1'b1;
    for (int i = 0; i < 5; i++) begin
      add_ts(1'b0, i < 4, ts);
      write_ts(ts);
      checks++; if (ifc.ts_tx_fifo_full !== (i >= 2)) begin errors++; $display("FAIL ovf_full[%0d]: got %b want %b", i, ifc.ts_tx_fifo_full, i >= 2); end
      checks++; if (overflow_err !== (i == 4)) begin errors++; $display("FAIL ovf_flag[%0d]: got %b want %b", i, overflow_err, i == 4); end
    end
    checks++; if (mon_q.size() != 0) begin errors++; $display("FAIL ovf_off_quiet: got %0d symbols want 0", mon_q.size()); end
    tx_enable = 1'b1;
    find_first(p, ok);
    if (!ok) return;
    for (int n = 0; n < 64; n++) begin
      if (n > 0) begin get_pulse(p, ok); if (!ok) return; end
      e = exp_q.pop_front();
      checks++; if (p.sym !== e || p.first !== (n % 16 == 0)) begin errors++; $display("FAIL ovf_drain[%0d]: got %h/%b want %h/%b", n, p.sym, p.first, e, n % 16 == 0); end
    end
    get_pulse(p, ok);
    if (!ok) return;
    checks++; if (p.sym !== 8'h00 || p.first !== 1'b0) begin errors++; $display("FAIL ovf_dropped: got %h/%b want 00/0", p.sym, p.first); end
    checks++; if (ifc.ts_tx_fifo_full !== 1'b0) begin errors++; $display("FAIL ovf_full_drained: got %b want 0", ifc.ts_tx_fifo_full); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
  endtask

  task automatic test_enable_drop();
    pulse_t p; bit ok; logic [127:0] ts; logic [7:0] e; int waited;
    do_reset();
    tx_enable = 1'b1;
    add_ts(1'b0, 1'b1, ts); write_ts(ts);
    add_ts(1'b0, 1'b0, ts); write_ts(ts);
    find_first(p, ok);
    if (!ok) return;
    for (int n = 0; n < 16; n++) begin
      if (n > 0) begin get_pulse(p, ok); if (!ok) return; end
      e = exp_q.pop_front();
      checks++; if (p.sym !== e) begin errors++; $display("FAIL drop_sym[%0d]: got %h want %h", n, p.sym, e); end
      if (n == 5) tx_enable = 1'b0;
    end
    waited = 0;
    while (ifc.tx_elec_idle !== 1'b1 && waited < 6) begin @(posedge clk); #1; waited++; end
    checks++; if (ifc.tx_elec_idle !== 1'b1) begin errors++; $display("FAIL drop_elec_idle: got %b want 1", ifc.tx_elec_idle); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (mon_q.size() != 0) begin errors++; $display("FAIL drop_quiet: got %0d symbols want 0", mon_q.size()); end
  endtask

  task automatic test_reset_mid();
    pulse_t p; bit ok; logic [127:0] ts; logic [7:0] e; int bad; int seen;
    do_reset();
    tx_enable = 1'b1;
    add_ts(1'b0, 1'b1, ts); write_ts(ts);
    add_ts(1'b0, 1'b0, ts); write_ts(ts);
    find_first(p, ok);
    if (!ok) return;
    void'(exp_q.pop_front());
    for (int n = 1; n <= 8; n++) begin
      get_pulse(p, ok);
      if (!ok) return;
      e = exp_q.pop_front();
      checks++; if (p.sym !== e) begin errors++; $display("FAIL rmid_sym[%0d]: got %h want %h", n, p.sym, e); end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (ifc.tx_sym !== 8'h00 || ifc.tx_k !== 1'b0) begin errors++; $display("FAIL rmid_sym_k: got %h/%b want 00/0", ifc.tx_sym, ifc.tx_k); end
    checks++; if (ifc.tx_sym_valid !== 1'b0 || ifc.tx_sym_first !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b/%b want 0/0", ifc.tx_sym_valid, ifc.tx_sym_first); end
    checks++; if (ifc.tx_elec_idle !== 1'b1) begin errors++; $display("FAIL rmid_elec_idle: got %b want 1", ifc.tx_elec_idle); end
    checks++; if (ifc.ts_tx_fifo_full !== 1'b0 || overflow_err !== 1'b0 || underrun_cnt !== 8'd0) begin
      errors++; $display("FAIL rmid_status: got full=%b ovf=%b urun=%0d want 0/0/0", ifc.ts_tx_fifo_full, overflow_err, underrun_cnt);
    end
    rst = 1'b0;
    mon_q.delete();
    repeat (60) @(posedge clk);
    #1;
    bad = 0;
    seen = mon_q.size();
    while (mon_q.size() > 0) begin
      p = mon_q.pop_front();
      if (p.sym !== 8'h00 || p.first !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rmid_no_partial: got %0d non-idle symbols want 0", bad); end
    checks++; if (seen == 0) begin errors++; $display("FAIL rmid_idles: got 0 idle symbols want some"); end
  endtask

  initial begin
    ifc.ts_in = '0;
    ifc.ts_in_valid = 1'b0;
    test_reset();
    test_single_ts();
    test_back_to_back();
    test_random_speed();
    test_overflow();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
